// File: rtl/uart_rx_parity.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_parity
// Purpose  : UART receiver with 16x oversampling, optional even/odd parity
//            and parity/framing error flags. Each received word is presented
//            on dout together with a one-clock rx_done_tick.
// Ports    : clk          - system clock
//            reset        - synchronous, active-high reset
//            s_tick       - one-clk enable pulse at 16x the baud rate
//            rx           - asynchronous serial input, idle high
//            dout         - last received data word (held between frames)
//            rx_done_tick - one-clk pulse when a frame completes
//            parity_err   - parity mismatch for the word in dout
//            frame_err    - stop bit sampled low for the word in dout
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_parity #(
  parameter int DBIT       = 8,   // data bits per frame (5..8)
  parameter int SB_TICK    = 16,  // s_ticks in the stop period (16/24/32)
  parameter int PARITY_EN  = 1,   // 1 = parity bit follows the data bits
  parameter int PARITY_ODD = 0    // 0 = even parity, 1 = odd parity
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            rx,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            parity_err,
  output logic            frame_err
);

  localparam logic [2:0] c_st_idle   = 3'd0;
  localparam logic [2:0] c_st_start  = 3'd1;
  localparam logic [2:0] c_st_data   = 3'd2;
  localparam logic [2:0] c_st_parity = 3'd3;
  localparam logic [2:0] c_st_stop   = 3'd4;

  localparam logic [4:0] c_mid_start = 5'd7;
  localparam logic [4:0] c_mid_bit   = 5'd15;
  localparam logic [4:0] c_stop_last = 5'(SB_TICK - 1);
  localparam logic [2:0] c_last_bit  = 3'(DBIT - 1);
  localparam logic       c_par_en    = (PARITY_EN != 0);
  localparam logic       c_par_odd   = (PARITY_ODD != 0);

  // Input synchronizer
  logic r_rx_meta;
  logic r_rx_s;

  // FSM and datapath
  logic [2:0]      r_state, w_state_next;
  logic [4:0]      r_s, w_s_next;
  logic [2:0]      r_n, w_n_next;
  logic [DBIT-1:0] r_shift, w_shift_next;
  logic            r_par, w_par_next;

  // Frame completion
  logic            w_complete;
  logic            w_parity_bad;

  // Registered outputs
  logic [DBIT-1:0] r_dout;
  logic            r_done;
  logic            r_perr;
  logic            r_ferr;

  // Both flops reset to the idle-line level so reset never fakes a start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_st_idle;
      r_s     <= '0;
      r_n     <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_s     <= w_s_next;
      r_n     <= w_n_next;
      r_shift <= w_shift_next;
      r_par   <= w_par_next;
    end
  end

  // Next-state logic; everything except the idle edge detect waits for s_tick.
  always_comb begin
    w_state_next = r_state;
    w_s_next     = r_s;
    w_n_next     = r_n;
    w_shift_next = r_shift;
    w_par_next   = r_par;
    case (r_state)
      c_st_idle: begin
        if (!r_rx_s) begin
          w_s_next     = '0;
          w_state_next = c_st_start;
        end
      end
      c_st_start: begin
        if (s_tick) begin
          if (r_s == c_mid_start) begin
            if (!r_rx_s) begin
              w_s_next     = '0;
              w_n_next     = '0;
              w_state_next = c_st_data;
            end else begin
              // Line high again at mid start bit: treat as a glitch.
              w_state_next = c_st_idle;
            end
          end else begin
            w_s_next = r_s + 5'd1;
          end
        end
      end
      c_st_data: begin
        if (s_tick) begin
          if (r_s == c_mid_bit) begin
            // Right shift: the first (LSB) bit ends up in bit 0.
            w_shift_next = {r_rx_s, r_shift[DBIT-1:1]};
            w_s_next     = '0;
            if (r_n == c_last_bit) begin
              w_state_next = c_par_en ? c_st_parity : c_st_stop;
            end else begin
              w_n_next = r_n + 3'd1;
            end
          end else begin
            w_s_next = r_s + 5'd1;
          end
        end
      end
      c_st_parity: begin
        if (s_tick) begin
          if (r_s == c_mid_bit) begin
            w_par_next   = r_rx_s;
            w_s_next     = '0;
            w_state_next = c_st_stop;
          end else begin
            w_s_next = r_s + 5'd1;
          end
        end
      end
      c_st_stop: begin
        if (s_tick) begin
          if (r_s == c_stop_last) begin
            w_state_next = c_st_idle;
          end else begin
            w_s_next = r_s + 5'd1;
          end
        end
      end
      default: w_state_next = c_st_idle;
    endcase
  end

  // Output decode: the frame completes on the last stop-period tick.
  always_comb begin
    w_complete   = (r_state == c_st_stop) && s_tick && (r_s == c_stop_last);
    w_parity_bad = c_par_en & (((^r_shift) ^ r_par) != c_par_odd);
  end

  // Outputs only change on frame completion; reset overrides completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dout <= '0;
      r_done <= 1'b0;
      r_perr <= 1'b0;
      r_ferr <= 1'b0;
    end else begin
      r_done <= w_complete;
      if (w_complete) begin
        r_dout <= r_shift;
        r_ferr <= ~r_rx_s;
        r_perr <= w_parity_bad;
      end
    end
  end

  assign dout         = r_dout;
  assign rx_done_tick = r_done;
  assign parity_err   = r_perr;
  assign frame_err    = r_ferr;

endmodule
`default_nettype wire
